// File: rtl/sram_controller_pkg.sv
// Shared widths, address window and FSM state encoding for the 32-bit to
// 16-bit SRAM bridge.
package sram_controller_pkg;

  localparam int LEN_REGISTER     = 32;
  localparam int SRAM_ADDR_LEN    = 18;
  localparam int SRAM_DATA_LEN    = 16;
  localparam int IDX_LEN          = SRAM_ADDR_LEN - 1;
  localparam int SRAM_WAIT_CYCLES = 3;
  localparam logic [LEN_REGISTER-1:0] SRAM_BASE = 32'd1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } sram_state_e;

  // Request captured on acceptance; the MEM-stage inputs are ignored afterwards.
  typedef struct packed {
    logic                    wr;
    logic [IDX_LEN-1:0]      idx;
    logic [LEN_REGISTER-1:0] data;
  } sram_req_t;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM cycles (low then high
// half-word), followed by a fixed settle period before handing ready back.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [LEN_REGISTER-1:0]  address,
  input  logic [LEN_REGISTER-1:0]  write_data,
  output logic [LEN_REGISTER-1:0]  read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic                     sram_we_n,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

  sram_state_e              state_q, state_d;
  logic [CW-1:0]            cnt_q;
  sram_req_t                req_q;
  logic [LEN_REGISTER-1:0]  addr_off;
  logic                     unused_addr_bits;

  // Offset wraps modulo 2^32; only the word index bits reach the SRAM.
  assign addr_off         = address - SRAM_BASE;
  assign unused_addr_bits = ^{addr_off[LEN_REGISTER-1:IDX_LEN+2], addr_off[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      read_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HIGH)      cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);
      if (state_q == IDLE && (rd_en || wr_en)) begin
        req_q.wr   <= wr_en;
        req_q.idx  <= addr_off[IDX_LEN+1:2];
        req_q.data <= write_data;
      end
      if (!req_q.wr) begin
        if (state_q == LOW)  read_data[15:0]  <= sram_dq_in;
        if (state_q == HIGH) read_data[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~rd_en & ~wr_en;
        if (rd_en || wr_en) state_d = LOW;
      end
      LOW: begin
        sram_addr = {req_q.idx, 1'b0};
        if (req_q.wr) begin
          sram_dq_out = req_q.data[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        state_d = HIGH;
      end
      HIGH: begin
        sram_addr = {req_q.idx, 1'b1};
        if (req_q.wr) begin
          sram_dq_out = req_q.data[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(WAIT_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, multi-cycle corner cases and
// randomized traffic against a word-level reference memory.
module tb_sram_controller;

  localparam int W   = 3;
  localparam int LAT = 3 + W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // Behavioural 2^18 x 16 SRAM: asynchronous read, write on clk edge.
  logic [15:0] sram_model [0:262143];
  assign sram_dq_in = sram_model[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_model[sram_addr] <= sram_dq_out;

  int checks = 0, errors = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 32'd4) % 32'd131072);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts in the cycle the request is first seen; returns just after the edge ending DONE.
  task automatic run_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd_seen, output int we_cnt, output int oe_cnt);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    lat = -1; rd_seen = '0; we_cnt = 0; oe_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) oe_cnt++;
      if (ready) begin lat = c; rd_seen = read_data; break; end
      if (c >= 1) begin address = $urandom; write_data = $urandom; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
    int lat, wc, oc;
    logic [31:0] rs;
    logic [17:0] lo;
    run_req(rd, wr, a, d, lat, rs, wc, oc);
    rd_en = 1'b0; wr_en = 1'b0;
    check({tag, " latency"}, lat, LAT);
    check({tag, " read_data"}, rs, exp_rd);
    check({tag, " we cycles"}, wc, wr ? 2 : 0);
    check({tag, " oe cycles"}, oc, wr ? 2 : 0);
    lo = 18'(widx(a) * 2);
    if (wr) begin
      ref_mem[widx(a)] = d;
      check({tag, " sram lo"}, 32'(sram_model[lo]), 32'(d[15:0]));
      check({tag, " sram hi"}, 32'(sram_model[lo + 18'd1]), 32'(d[31:16]));
    end else begin
      last_rd = exp_rd;
    end
  endtask

  initial begin
    int lat2;
    bit rd, wr;
    logic [31:0] a, d, e;

    tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b1, 32'd1036, 32'h12345678, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 32'd1038, 32'h0,        32'h12345678};
    tbl[4] = '{1'b1, 1'b1, 32'd1028, 32'h0000A5A5, 32'h12345678};
    tbl[5] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h0000A5A5};
    tbl[6] = '{1'b0, 1'b1, 32'd0,    32'hCAFEF00D, 32'h0000A5A5};
    tbl[7] = '{1'b1, 1'b0, 32'd3,    32'h0,        32'hCAFEF00D};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", 32'(ready), 32'd1);
    check("reset we_n", 32'(sram_we_n), 32'd1);
    check("reset oe", 32'(sram_dq_oe), 32'd0);
    check("reset addr", 32'(sram_addr), 32'd0);
    check("reset dq_out", 32'(sram_dq_out), 32'd0);
    check("reset read_data", read_data, 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle outputs", 32'({ready, sram_we_n, ~sram_dq_oe, sram_addr == 18'd0}), 32'hF);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd);

    check("mem[0]", 32'(sram_model[0]), 32'hBEEF);
    check("mem[1]", 32'(sram_model[1]), 32'hDEAD);
    check("mem[6]", 32'(sram_model[6]), 32'h5678);
    check("mem[7]", 32'(sram_model[7]), 32'h1234);
    check("mem[2]", 32'(sram_model[2]), 32'hA5A5);
    check("mem[3]", 32'(sram_model[3]), 32'h0000);
    check("mem wrap", 32'(sram_model[18'h3FE00]), 32'hF00D);

    // Back-to-back reads with rd_en held across DONE.
    begin
      int l1, wc, oc;
      logic [31:0] rs;
      run_req(1'b1, 1'b0, 32'd1024, 32'h0, l1, rs, wc, oc);
      check("b2b first latency", l1, LAT);
      check("b2b first data", rs, 32'hDEADBEEF);
      address = 32'd1028;
      @(negedge clk);
      check("b2b idle ready", 32'(ready), 32'd0);
      check("b2b idle addr", 32'(sram_addr), 32'd0);
      @(negedge clk);
      check("b2b low addr", 32'(sram_addr), 32'd2);
      lat2 = -1;
      for (int c = LAT + 3; c < 60; c++) begin
        @(negedge clk);
        if (ready) begin lat2 = c; break; end
      end
      check("b2b second latency", lat2, 2 * LAT + 1);
      check("b2b second data", read_data, 32'h0000A5A5);
      @(posedge clk); #1;
      rd_en = 1'b0;
      last_rd = 32'h0000A5A5;
    end

    // Reset during HIGH of a read; held rd_en restarts a full access.
    rd_en = 1'b1; address = 32'd1024;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst read_data", read_data, 32'd0);
    check("midrst ready", 32'(ready), 32'd0);
    check("midrst addr", 32'(sram_addr), 32'd0);
    do_op("midrst restart", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      if (!wr && !ref_mem.exists(widx(a))) wr = 1'b1;
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = $urandom;
      e  = wr ? last_rd : ref_mem[widx(a)];
      do_op("rand", rd, wr, a, d, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
